event_packer: RTL

Upstream front end of the convolution layer. It accepts single-channel spike events (x, y, channel) and end-of-timestep markers over a valid/ready handshake. Consecutive events at the same pixel are merged into one IN_CHANNELS-wide spike vector. Packed words are written into the layer's input FIFO using its write_enable / full_next protocol.

---
 rtl/event_packer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/event_packer.sv
// event_packer: merges per-pixel spike events into channel vectors and
// writes packed {ts, x, y, spikes} words into the conv-layer input FIFO.
module event_packer #(
   parameter int IN_CHANNELS         = 2,
   parameter int IMG_WIDTH           = 32,
   parameter int IMG_HEIGHT          = 32,
   parameter int BITS_PER_COORDINATE = 8,
   parameter int FLUSH_TIMEOUT       = 16,
   localparam int CW = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1,
   localparam int DW = 2 * BITS_PER_COORDINATE + IN_CHANNELS + 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic                           in_is_timestep,
   input  logic [BITS_PER_COORDINATE-1:0] in_x,
   input  logic [BITS_PER_COORDINATE-1:0] in_y,
   input  logic [CW-1:0]                  in_channel,
   output logic                           out_write_enable,
   output logic [DW-1:0]                  out_data,
   input  logic                           out_full_next,
   output logic [15:0]                    dropped_count
);

   localparam int TW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
   localparam int B  = BITS_PER_COORDINATE;

   typedef enum logic [1:0] {IDLE, ACCUM, EMIT_TS} state_t;

   state_t                 state;
   logic [B-1:0]           pend_x;
   logic [B-1:0]           pend_y;
   logic [IN_CHANNELS-1:0] pend_spikes;
   logic [TW-1:0]          idle_cnt;

   logic                   is_event;
   logic                   coord_ok;
   logic                   same_pix;
   logic                   accept;
   logic                   ev_acc;
   logic                   ts_acc;
   logic                   bad_acc;
   logic                   timeout;
   logic [IN_CHANNELS-1:0] onehot;
   logic [DW-1:0]          pend_word;
   logic [DW-1:0]          ts_word;

   assign is_event = in_valid && !in_is_timestep;
   assign coord_ok = (32'(in_x) < IMG_WIDTH) && (32'(in_y) < IMG_HEIGHT)
                     && (32'(in_channel) < IN_CHANNELS);
   assign same_pix = (state == ACCUM) && (in_x == pend_x) && (in_y == pend_y);
   assign onehot   = IN_CHANNELS'(1) << in_channel;

   assign pend_word = {1'b0, pend_x, pend_y, pend_spikes};
   assign ts_word   = {1'b1, {(DW-1){1'b0}}};

   // Same-pixel merges and drops never write, so they bypass FIFO backpressure.
   always_comb begin
      in_ready = 1'b0;
      if (!reset) begin
         unique case (state)
            IDLE:    in_ready = !out_full_next;
            ACCUM:   in_ready = (is_event && (!coord_ok || same_pix)) || !out_full_next;
            EMIT_TS: in_ready = 1'b0;
            default: in_ready = 1'b0;
         endcase
      end
   end

   assign accept  = in_valid && in_ready;
   assign ev_acc  = accept && is_event && coord_ok;
   assign ts_acc  = accept && in_is_timestep;
   assign bad_acc = accept && is_event && !coord_ok;
   assign timeout = (FLUSH_TIMEOUT != 0) && (idle_cnt == TW'(FLUSH_TIMEOUT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         pend_x           <= '0;
         pend_y           <= '0;
         pend_spikes      <= '0;
         idle_cnt         <= '0;
         dropped_count    <= '0;
         out_write_enable <= 1'b0;
         out_data         <= '0;
      end else begin
         out_write_enable <= 1'b0;
         if (bad_acc && dropped_count != 16'hFFFF)
            dropped_count <= dropped_count + 16'd1;
         unique case (state)
            IDLE: begin
               idle_cnt <= '0;
               if (ev_acc) begin
                  pend_x      <= in_x;
                  pend_y      <= in_y;
                  pend_spikes <= onehot;
                  state       <= ACCUM;
               end else if (ts_acc) begin
                  out_write_enable <= 1'b1;
                  out_data         <= ts_word;
               end
            end
            ACCUM: begin
               if (ev_acc) begin
                  idle_cnt <= '0;
                  if (same_pix) begin
                     pend_spikes <= pend_spikes | onehot;
                  end else begin
                     out_write_enable <= 1'b1;
                     out_data         <= pend_word;
                     pend_x           <= in_x;
                     pend_y           <= in_y;
                     pend_spikes      <= onehot;
                  end
               end else if (ts_acc) begin
                  // Vector goes first; the marker follows from EMIT_TS.
                  out_write_enable <= 1'b1;
                  out_data         <= pend_word;
                  idle_cnt         <= '0;
                  state            <= EMIT_TS;
               end else if (timeout && !out_full_next) begin
                  out_write_enable <= 1'b1;
                  out_data         <= pend_word;
                  idle_cnt         <= '0;
                  state            <= IDLE;
               end else if (!timeout && FLUSH_TIMEOUT != 0) begin
                  idle_cnt <= idle_cnt + TW'(1);
               end
            end
            EMIT_TS: begin
               if (!out_full_next) begin
                  out_write_enable <= 1'b1;
                  out_data         <= ts_word;
                  state            <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
